// File: rtl/cell_ram_arbiter.sv
// ---------------------------------------------------------------------------
// cell_ram_arbiter
//
// Shares one single-port synchronous cell RAM between a CPU bus port
// (read/write) and a display-fetch port (read only). One access runs at a
// time: IDLE -> ACC_x -> RESP_x -> IDLE, so every access takes three cycles
// and the ack arrives two cycles after the request is seen in IDLE.
//
// When both ports request together the display normally wins. A streak
// counter limits how many display grants may happen in a row while the CPU
// is waiting; at STARVE_MAX the CPU gets the next slot.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata      CPU handshake and read data
//   disp_req/addr           display read request (held until disp_ack)
//   disp_ack, disp_rdata    display handshake and read data
//   mem_addr/we/din         registered RAM controls
//   mem_dout                RAM read data, valid the cycle after the address edge
//   busy                    high whenever an access is in flight
// ---------------------------------------------------------------------------
module cell_ram_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    ACC_CPU,
    ACC_DISP,
    RESP_CPU,
    RESP_DISP
  } state_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_MAX);

  state_t              state_reg,      state_next;
  logic [3:0]          streak_reg,     streak_next;
  logic [ADDR_W-1:0]   mem_addr_reg,   mem_addr_next;
  logic                mem_we_reg,     mem_we_next;
  logic [DATA_W-1:0]   mem_din_reg,    mem_din_next;
  // Remembers that the CPU access in flight is a write, because mem_we has
  // already dropped by the time the response cycle decides on the hold update.
  logic                acc_write_reg,  acc_write_next;
  logic [DATA_W-1:0]   cpu_hold_reg,   cpu_hold_next;
  logic [DATA_W-1:0]   disp_hold_reg,  disp_hold_next;

  logic                grant_disp;

  // Display wins a contested slot unless the CPU has waited out its streak.
  assign grant_disp = disp_req && (!cpu_req || (streak_reg != STREAK_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_din_reg   <= '0;
      acc_write_reg <= 1'b0;
      cpu_hold_reg  <= '0;
      disp_hold_reg <= '0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      mem_addr_reg  <= mem_addr_next;
      mem_we_reg    <= mem_we_next;
      mem_din_reg   <= mem_din_next;
      acc_write_reg <= acc_write_next;
      cpu_hold_reg  <= cpu_hold_next;
      disp_hold_reg <= disp_hold_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    streak_next    = streak_reg;
    mem_addr_next  = mem_addr_reg;
    mem_we_next    = mem_we_reg;
    mem_din_next   = mem_din_reg;
    acc_write_next = acc_write_reg;
    cpu_hold_next  = cpu_hold_reg;
    disp_hold_next = disp_hold_reg;

    unique case (state_reg)
      IDLE: begin
        if (grant_disp) begin
          state_next    = ACC_DISP;
          mem_addr_next = disp_addr;
          mem_we_next   = 1'b0;
          // Count only display grants that keep a pending CPU waiting.
          if (!cpu_req) begin
            streak_next = '0;
          end else if (streak_reg != STREAK_LIMIT) begin
            streak_next = streak_reg + 4'd1;
          end
        end else if (cpu_req) begin
          state_next     = ACC_CPU;
          mem_addr_next  = cpu_addr;
          mem_we_next    = cpu_we;
          mem_din_next   = cpu_wdata;
          acc_write_next = cpu_we;
          streak_next    = '0;
        end else begin
          streak_next = '0;
        end
      end

      ACC_CPU: begin
        // The RAM samples the write at this edge; the strobe lasts one cycle.
        state_next  = RESP_CPU;
        mem_we_next = 1'b0;
      end

      ACC_DISP: begin
        state_next = RESP_DISP;
      end

      RESP_CPU: begin
        state_next = IDLE;
        if (!acc_write_reg) begin
          cpu_hold_next = mem_dout;
        end
      end

      RESP_DISP: begin
        state_next     = IDLE;
        disp_hold_next = mem_dout;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign cpu_ack  = (state_reg == RESP_CPU);
  assign disp_ack = (state_reg == RESP_DISP);
  assign mem_addr = mem_addr_reg;
  assign mem_we   = mem_we_reg;
  assign mem_din  = mem_din_reg;

  // Read data passes straight through in the response cycle and is held
  // afterwards; a CPU write response keeps showing the previous read value.
  assign cpu_rdata  = ((state_reg == RESP_CPU) && !acc_write_reg) ? mem_dout : cpu_hold_reg;
  assign disp_rdata = (state_reg == RESP_DISP) ? mem_dout : disp_hold_reg;

endmodule

// File: tb/tb_cell_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cell_ram_arbiter
//
// Drives cell_ram_arbiter against a synchronous RAM model. Directed tasks
// cover reset, single CPU write/read, display read, contention, starvation
// limit, dropped request and reset mid-access. A randomized task checks every
// cycle against a timeline model: each arbitration slot is an integer cycle,
// and acks, busy, write strobes and read data are predicted from it.
// ---------------------------------------------------------------------------
module tb_cell_ram_arbiter;

  localparam int AW          = 7;
  localparam int DW          = 32;
  localparam int STARVE      = 4;
  localparam int RAND_CYCLES = 1500;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic [DW-1:0] disp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          busy;

  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;
  logic [DW-1:0] ram       [0:(1<<AW)-1];
  logic [DW-1:0] model_ram [0:(1<<AW)-1];

  int n_tests;
  int n_fail;

  cell_ram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(STARVE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_ack  (disp_ack),
    .disp_rdata(disp_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM; the bench can preload words through poke.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if ({cpu_ack, disp_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {cpu_ack, disp_ack}); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_tests++; if (mem_din !== '0) begin n_fail++; $display("FAIL reset_mem_din: got %h want 0", mem_din); end
    n_tests++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    n_tests++; if (disp_rdata !== '0) begin n_fail++; $display("FAIL reset_disp_rdata: got %h want 0", disp_rdata); end
    rst = 1'b1;
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h05; cpu_wdata = 32'hDEADBEEF;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_c0: got %b want 0", busy); end
    tick();
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we_c1: got %b want 1", mem_we); end
    n_tests++; if (mem_addr !== 7'h05) begin n_fail++; $display("FAIL wr_mem_addr_c1: got %h want 05", mem_addr); end
    n_tests++; if (mem_din !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem_din_c1: got %h want deadbeef", mem_din); end
    n_tests++; if ({busy, cpu_ack} !== 2'b10) begin n_fail++; $display("FAIL wr_busy_ack_c1: got %b want 10", {busy, cpu_ack}); end
    tick();
    n_tests++; if ({busy, cpu_ack, mem_we} !== 3'b110) begin n_fail++; $display("FAIL wr_busy_ack_we_c2: got %b want 110", {busy, cpu_ack, mem_we}); end
    cpu_req = 1'b0;
    tick();
    n_tests++; if ({busy, cpu_ack} !== 2'b00) begin n_fail++; $display("FAIL wr_busy_ack_c3: got %b want 00", {busy, cpu_ack}); end
    $display("[TB] cpu write addr=05 data=deadbeef done");
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h05;
    tick();
    n_tests++; if ({cpu_ack, mem_we} !== 2'b00) begin n_fail++; $display("FAIL rd_ack_we_c1: got %b want 00", {cpu_ack, mem_we}); end
    tick();
    n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack_c2: got %b want 1", cpu_ack); end
    n_tests++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data_c2: got %h want deadbeef", cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    tick();
    n_tests++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data_held: got %h want deadbeef", cpu_rdata); end
    $display("[TB] cpu read addr=05 rdata=%h", cpu_rdata);
  endtask

  task automatic test_display_read();
    poke(7'h7F, 32'h0000FFFF);
    disp_req = 1'b1; disp_addr = 7'h7F;
    tick();
    n_tests++; if (disp_ack !== 1'b0) begin n_fail++; $display("FAIL disp_ack_c1: got %b want 0", disp_ack); end
    tick();
    n_tests++; if (disp_ack !== 1'b1) begin n_fail++; $display("FAIL disp_ack_c2: got %b want 1", disp_ack); end
    n_tests++; if (disp_rdata !== 32'h0000FFFF) begin n_fail++; $display("FAIL disp_data_c2: got %h want 0000ffff", disp_rdata); end
    n_tests++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL disp_cpu_rdata: got %h want deadbeef", cpu_rdata); end
    disp_req = 1'b0;
    tick();
    n_tests++; if (disp_rdata !== 32'h0000FFFF) begin n_fail++; $display("FAIL disp_data_held: got %h want 0000ffff", disp_rdata); end
    $display("[TB] display read addr=7f rdata=%h", disp_rdata);
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_acks;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h05;
    disp_req = 1'b1; disp_addr = 7'h7F;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_acks = (i == 2) ? 2'b01 : (i == 5) ? 2'b10 : 2'b00;
      n_tests++; if ({cpu_ack, disp_ack} !== exp_acks) begin n_fail++; $display("FAIL simul_acks cycle %0d: got %b want %b", i, {cpu_ack, disp_ack}, exp_acks); end
      if (i == 2) disp_req = 1'b0;
      if (i == 5) cpu_req = 1'b0;
    end
    $display("[TB] simultaneous requests: display first, cpu 3 cycles later");
  endtask

  task automatic test_starvation();
    logic [1:0] exp_acks;
    logic       exp_busy;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h05;
    disp_req = 1'b1; disp_addr = 7'h7F;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp_busy = ((i % 3) != 0);
      exp_acks = 2'b00;
      // Access k is acked at cycle 3k+2; every fifth grant goes to the CPU.
      if ((i % 3) == 2) exp_acks = ((((i - 2) / 3) % (STARVE + 1)) == STARVE) ? 2'b10 : 2'b01;
      n_tests++; if ({cpu_ack, disp_ack} !== exp_acks) begin n_fail++; $display("FAIL starve_acks cycle %0d: got %b want %b", i, {cpu_ack, disp_ack}, exp_acks); end
      n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL starve_busy cycle %0d: got %b want %b", i, busy, exp_busy); end
    end
    cpu_req = 1'b0; disp_req = 1'b0;
    tick();
    $display("[TB] starvation order D,D,D,D,C x2 done");
  endtask

  task automatic test_dropped_request();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h05;
    tick();
    cpu_req = 1'b0;
    tick();
    n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got %b want 1", cpu_ack); end
    n_tests++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL drop_data: got %h want deadbeef", cpu_rdata); end
    tick();
    tick();
    n_tests++; if ({busy, cpu_ack, disp_ack} !== 3'b000) begin n_fail++; $display("FAIL drop_after: got %b want 000", {busy, cpu_ack, disp_ack}); end
    $display("[TB] dropped request completed");
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h11; cpu_wdata = 32'hA5A50011;
    tick();
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_we_before: got %b want 1", mem_we); end
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if ({mem_we, busy, cpu_ack} !== 3'b000) begin n_fail++; $display("FAIL rstmid_async: got %b want 000", {mem_we, busy, cpu_ack}); end
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0", mem_addr); end
    tick();
    n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ack: got %b want 0", cpu_ack); end
    rst = 1'b1;
    tick();
    n_tests++; if ({mem_we, cpu_ack} !== 2'b10) begin n_fail++; $display("FAIL rstmid_reissue_c1: got %b want 10", {mem_we, cpu_ack}); end
    n_tests++; if (mem_addr !== 7'h11) begin n_fail++; $display("FAIL rstmid_reissue_addr: got %h want 11", mem_addr); end
    tick();
    n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_reissue_ack: got %b want 1", cpu_ack); end
    cpu_req = 1'b0;
    tick();
    n_tests++; if (ram[7'h11] !== 32'hA5A50011) begin n_fail++; $display("FAIL rstmid_ram: got %h want a5a50011", ram[7'h11]); end
    $display("[TB] reset mid-access, write reissued");
  endtask

  task automatic test_random();
    int            next_arb, ack_cyc, we_cyc, streak;
    bit            ack_is_cpu, ack_is_read, cpu_done, disp_done, cpu_win;
    logic [DW-1:0] ack_val, we_data, cpu_hold, disp_hold, exp_cpu_rd, exp_disp_rd;
    logic [AW-1:0] we_addr;
    logic          exp_cpu_ack, exp_disp_ack, exp_busy, exp_we;
    int            n_grants;
    rst = 1'b0; cpu_req = 1'b0; disp_req = 1'b0;
    tick();
    for (int a = 0; a < (1 << AW); a++) begin
      model_ram[a] = $urandom;
      poke(AW'(a), model_ram[a]);
    end
    rst = 1'b1;
    next_arb = 0; ack_cyc = -1; we_cyc = -1; streak = 0; n_grants = 0;
    cpu_hold = '0; disp_hold = '0; cpu_done = 1'b0; disp_done = 1'b0;
    ack_is_cpu = 1'b0; ack_is_read = 1'b0; ack_val = '0; we_addr = '0; we_data = '0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      if (!cpu_req || cpu_done) begin
        cpu_req   = ($urandom_range(0, 1) == 1);
        cpu_we    = ($urandom_range(0, 1) == 1);
        cpu_addr  = AW'($urandom);
        cpu_wdata = $urandom;
      end
      if (!disp_req || disp_done) begin
        disp_req  = ($urandom_range(0, 3) != 0);
        disp_addr = AW'($urandom);
      end
      cpu_done = 1'b0; disp_done = 1'b0;

      exp_busy     = (c < next_arb);
      exp_cpu_ack  = (ack_cyc == c) && ack_is_cpu;
      exp_disp_ack = (ack_cyc == c) && !ack_is_cpu;
      exp_cpu_rd   = (exp_cpu_ack && ack_is_read) ? ack_val : cpu_hold;
      exp_disp_rd  = exp_disp_ack ? ack_val : disp_hold;
      exp_we       = (we_cyc == c);
      n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cycle %0d: got %b want %b", c, busy, exp_busy); end
      n_tests++; if ({cpu_ack, disp_ack} !== {exp_cpu_ack, exp_disp_ack}) begin n_fail++; $display("FAIL rnd_acks cycle %0d: got %b want %b", c, {cpu_ack, disp_ack}, {exp_cpu_ack, exp_disp_ack}); end
      n_tests++; if (cpu_rdata !== exp_cpu_rd) begin n_fail++; $display("FAIL rnd_cpu_rdata cycle %0d: got %h want %h", c, cpu_rdata, exp_cpu_rd); end
      n_tests++; if (disp_rdata !== exp_disp_rd) begin n_fail++; $display("FAIL rnd_disp_rdata cycle %0d: got %h want %h", c, disp_rdata, exp_disp_rd); end
      n_tests++; if (mem_we !== exp_we) begin n_fail++; $display("FAIL rnd_mem_we cycle %0d: got %b want %b", c, mem_we, exp_we); end
      if (exp_we) begin
        n_tests++; if ({mem_addr, mem_din} !== {we_addr, we_data}) begin n_fail++; $display("FAIL rnd_write cycle %0d: got %h/%h want %h/%h", c, mem_addr, mem_din, we_addr, we_data); end
      end

      if (ack_cyc == c) begin
        if (ack_is_cpu) begin
          cpu_done = 1'b1;
          if (ack_is_read) cpu_hold = ack_val;
        end else begin
          disp_done = 1'b1;
          disp_hold = ack_val;
        end
      end

      if (c == next_arb) begin
        if (cpu_req || disp_req) begin
          cpu_win    = cpu_req && (!disp_req || streak == STARVE);
          ack_cyc    = c + 2;
          next_arb   = c + 3;
          ack_is_cpu = cpu_win;
          n_grants++;
          if (cpu_win) begin
            streak      = 0;
            ack_is_read = !cpu_we;
            if (cpu_we) begin
              model_ram[cpu_addr] = cpu_wdata;
              we_cyc  = c + 1;
              we_addr = cpu_addr;
              we_data = cpu_wdata;
            end else begin
              ack_val = model_ram[cpu_addr];
            end
          end else begin
            streak  = cpu_req ? ((streak < STARVE) ? streak + 1 : STARVE) : 0;
            ack_val = model_ram[disp_addr];
          end
        end else begin
          next_arb = c + 1;
          streak   = 0;
        end
      end
      tick();
    end
    cpu_req = 1'b0; disp_req = 1'b0;
    tick();
    $display("[TB] random: %0d cycles, %0d grants", RAND_CYCLES, n_grants);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_req = 1'b0; disp_addr = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_display_read();
    test_simultaneous();
    test_starvation();
    test_dropped_request();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
